// File: rtl/intdiv_sd2_serializer_pkg.sv
// Shared SD2 digit encodings and serializer FSM state type.
package intdiv_sd2_serializer_pkg;

    localparam logic [1:0] SD2_POS1 = 2'b01;
    localparam logic [1:0] SD2_NEG1 = 2'b11;
    localparam logic [1:0] SD2_ZERO = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAD   = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

endpackage

// File: rtl/intdiv_sd2_enc.sv
// Single-bit to SD2 digit encoder: a set bit becomes +1 or -1 by its sign, a clear bit is zero.
module intdiv_sd2_enc
    import intdiv_sd2_serializer_pkg::*;
(
    input  logic       i_bit,
    input  logic       i_sign,
    output logic [1:0] o_digit
);

    assign o_digit = i_bit ? (i_sign ? SD2_NEG1 : SD2_POS1) : SD2_ZERO;

endmodule

// File: rtl/intdiv_sd2_serializer.sv
// Streams a WIDTH-bit operand as MSB-first radix-2 signed digits, preceded by PAD zero digits,
// under valid/ready handshakes on both sides.
module intdiv_sd2_serializer
    import intdiv_sd2_serializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PAD   = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_sign,
    input  logic             i_in_mode,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [1:0]       o_out_digit,
    output logic             o_out_last,
    output logic             o_busy
);

    localparam int TOTAL = PAD + WIDTH;
    localparam int CW    = $clog2(TOTAL + 1);

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic             r_sign, r_mode;
    logic [CW-1:0]    r_idx, w_idx_nxt;
    logic             r_out_valid, w_valid_nxt;
    logic [1:0]       r_out_digit, w_digit_nxt;
    logic             r_out_last, w_last_nxt;

    logic             w_idle, w_load;
    logic [WIDTH-1:0] w_src_data, w_mask;
    logic             w_src_sign, w_src_mode;
    logic [CW-1:0]    w_pos, w_rem;
    logic             w_is_pad, w_bit, w_neg;
    logic [1:0]       w_enc;

    // The digit for position w_pos is prepared one cycle ahead so out_digit stays registered;
    // on accept the operand is taken straight from the inputs since it is not latched yet.
    assign w_idle     = (r_state == ST_IDLE);
    assign w_load     = w_idle && i_in_valid && !i_flush;
    assign w_src_data = w_idle ? i_in_data : r_data;
    assign w_src_sign = w_idle ? i_in_sign : r_sign;
    assign w_src_mode = w_idle ? i_in_mode : r_mode;
    assign w_pos      = w_idle ? '0 : r_idx + CW'(1);
    assign w_rem      = CW'(TOTAL - 1) - w_pos;
    assign w_mask     = {{(WIDTH-1){1'b0}}, 1'b1} << w_rem;
    assign w_is_pad   = int'(w_pos) < PAD;
    assign w_bit      = !w_is_pad && (|(w_src_data & w_mask));
    assign w_neg      = w_src_sign ^ (w_src_mode & (int'(w_pos) == PAD));

    intdiv_sd2_enc u_enc (
        .i_bit   (w_bit),
        .i_sign  (w_neg),
        .o_digit (w_enc)
    );

    always_comb begin
        // NOTE: every output of this block is given a default first so no path infers a latch.
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_out_valid;
        w_digit_nxt = r_out_digit;
        w_last_nxt  = r_out_last;
        if (i_flush) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_digit_nxt = SD2_ZERO;
            w_last_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        w_state_nxt = w_is_pad ? ST_PAD : ST_SHIFT;
                        w_idx_nxt   = w_pos;
                        w_valid_nxt = 1'b1;
                        w_digit_nxt = w_enc;
                        w_last_nxt  = (int'(w_pos) == TOTAL - 1);
                    end
                end
                default: begin
                    if (r_out_valid && i_out_ready) begin
                        if (r_out_last) begin
                            w_state_nxt = ST_IDLE;
                            w_idx_nxt   = '0;
                            w_valid_nxt = 1'b0;
                            w_digit_nxt = SD2_ZERO;
                            w_last_nxt  = 1'b0;
                        end else begin
                            w_state_nxt = w_is_pad ? ST_PAD : ST_SHIFT;
                            w_idx_nxt   = w_pos;
                            w_valid_nxt = 1'b1;
                            w_digit_nxt = w_enc;
                            w_last_nxt  = (int'(w_pos) == TOTAL - 1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_digit <= SD2_ZERO;
            r_out_last  <= 1'b0;
            r_data      <= '0;
            r_sign      <= 1'b0;
            r_mode      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_digit <= w_digit_nxt;
            r_out_last  <= w_last_nxt;
            if (w_load) begin
                r_data <= i_in_data;
                r_sign <= i_in_sign;
                r_mode <= i_in_mode;
            end
        end
    end

    assign o_in_ready  = w_idle;
    assign o_busy      = !w_idle;
    assign o_out_valid = r_out_valid;
    assign o_out_digit = r_out_digit;
    assign o_out_last  = r_out_last;

endmodule

// File: tb/tb_intdiv_sd2_serializer.sv
// Bench for intdiv_sd2_serializer: directed vector table, hand-written backpressure/flush/reset
// sequences and randomized operands checked against a digit-rule and numeric-value model.
module tb_intdiv_sd2_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_sign, in_mode, out_ready;
    logic [W-1:0] in_data;
    logic         in_ready0, out_valid0, out_last0, busy0;
    logic [1:0]   out_digit0;
    logic         in_ready1, out_valid1, out_last1, busy1;
    logic [1:0]   out_digit1;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] got_q[$];
    bit         last_q[$];
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    intdiv_sd2_serializer #(.WIDTH(W), .PAD(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready0),
        .i_in_data(in_data), .i_in_sign(in_sign), .i_in_mode(in_mode), .o_out_valid(out_valid0),
        .i_out_ready(out_ready), .o_out_digit(out_digit0), .o_out_last(out_last0), .o_busy(busy0)
    );

    intdiv_sd2_serializer #(.WIDTH(W), .PAD(2)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready1),
        .i_in_data(in_data), .i_in_sign(in_sign), .i_in_mode(in_mode), .o_out_valid(out_valid1),
        .i_out_ready(out_ready), .o_out_digit(out_digit1), .o_out_last(out_last1), .o_busy(busy1)
    );

    typedef struct {
        int           sel;
        logic [W-1:0] data;
        logic         sign;
        logic         mode;
        logic [39:0]  exp;
        int           len;
    } vec_t;

    vec_t vecs[6];

    function automatic logic get_valid(input int sel); return sel == 0 ? out_valid0 : out_valid1; endfunction
    function automatic logic get_last(input int sel);  return sel == 0 ? out_last0  : out_last1;  endfunction
    function automatic logic get_ready(input int sel); return sel == 0 ? in_ready0  : in_ready1;  endfunction
    function automatic logic get_busy(input int sel);  return sel == 0 ? busy0      : busy1;      endfunction
    function automatic logic [1:0] get_digit(input int sel); return sel == 0 ? out_digit0 : out_digit1; endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (!busy0 && !busy1) ok = 1;
            else step();
        end
        check("idle_reached", {31'd0, ok}, 32'd1);
    endtask

    task automatic offer(input int sel, input logic [W-1:0] d, input logic s, input logic m);
        check("in_ready_before_accept", {31'd0, get_ready(sel)}, 32'd1);
        in_valid = 1'b1; in_data = d; in_sign = s; in_mode = m;
        step();
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_sign  = 1'($urandom);
        in_mode  = 1'($urandom);
        check("first_digit_next_cycle", {31'd0, get_valid(sel)}, 32'd1);
    endtask

    // Accept digits until out_last; optionally random backpressure and ignored in_valid pulses.
    task automatic collect(input int sel, input bit rnd);
        bit done = 0;
        bit hv, hr, hl;
        logic [1:0] hd;
        got_q.delete();
        last_q.delete();
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            hr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_ready = hr;
            in_valid  = (rnd && busy0 && busy1) ? 1'($urandom) : 1'b0;
            hv = get_valid(sel); hd = get_digit(sel); hl = get_last(sel);
            if (hv) check("in_ready_low_while_busy", {31'd0, get_ready(sel)}, 32'd0);
            if (hv && hr) begin
                got_q.push_back(hd);
                last_q.push_back(hl);
                if (hl) done = 1;
            end
            step();
            if (hv && !hr) begin
                check("hold_valid", {31'd0, get_valid(sel)}, 32'd1);
                check("hold_digit", {30'd0, get_digit(sel)}, {30'd0, hd});
                check("hold_last", {31'd0, get_last(sel)}, {31'd0, hl});
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_completed", {31'd0, done}, 32'd1);
        if (done) begin
            check("valid_low_after_last", {31'd0, get_valid(sel)}, 32'd0);
            check("in_ready_after_last", {31'd0, get_ready(sel)}, 32'd1);
        end
    endtask

    task automatic compare(input string name);
        int n;
        check({name, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_digit%0d", name, k), {30'd0, got_q[k]}, {30'd0, exp_q[k]});
            check($sformatf("%s_last%0d", name, k), {31'd0, last_q[k]}, (k == exp_q.size() - 1) ? 32'd1 : 32'd0);
        end
    endtask

    function automatic logic [1:0] code_of(input int v);
        return (v > 0) ? 2'b01 : (v < 0) ? 2'b11 : 2'b00;
    endfunction

    function automatic int value_of(input logic [1:0] c);
        return (c == 2'b01) ? 1 : (c == 2'b11) ? -1 : 0;
    endfunction

    // Reference stream: PAD zeros, then bit b contributes +/-2^b; the MSB weight is negative in
    // two's-complement mode, and the whole value flips when sign is set.
    task automatic build_exp(input int pad, input logic [W-1:0] d, input logic s, input logic m);
        bit neg;
        exp_q.delete();
        for (int p = 0; p < pad; p++) exp_q.push_back(2'b00);
        for (int b = W - 1; b >= 0; b--) begin
            neg = s ^ (m && (b == W - 1));
            exp_q.push_back(d[b] ? code_of(neg ? -1 : 1) : 2'b00);
        end
    endtask

    task automatic check_value(input logic [W-1:0] d, input logic s, input logic m);
        int got, want;
        got = 0;
        foreach (got_q[k]) got = got * 2 + value_of(got_q[k]);
        want = m ? int'($signed(d)) : int'(d);
        if (s) want = -want;
        check("stream_value", got, want);
    endtask

    initial begin
        logic [1:0] pre[$];
        int         sel;
        logic [W-1:0] d;
        logic       s, m;

        vecs[0] = '{0, 8'hA1, 1'b0, 1'b0, 40'h4401,  8};
        vecs[1] = '{0, 8'hA1, 1'b1, 1'b0, 40'hCC03,  8};
        vecs[2] = '{0, 8'hFF, 1'b0, 1'b1, 40'hD555,  8};
        vecs[3] = '{0, 8'hFF, 1'b1, 1'b1, 40'h7FFF,  8};
        vecs[4] = '{1, 8'h80, 1'b0, 1'b0, 40'h04000, 10};
        vecs[5] = '{0, 8'h80, 1'b0, 1'b1, 40'hC000,  8};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        in_sign = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_in_ready", {31'd0, get_ready(i)}, 32'd1);
            check("reset_out_valid", {31'd0, get_valid(i)}, 32'd0);
            check("reset_out_digit", {30'd0, get_digit(i)}, 32'd0);
            check("reset_out_last", {31'd0, get_last(i)}, 32'd0);
            check("reset_busy", {31'd0, get_busy(i)}, 32'd0);
        end
        step(); step();
        rst = 1'b0;
        step();

        // Directed vectors at full throughput.
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            offer(vecs[i].sel, vecs[i].data, vecs[i].sign, vecs[i].mode);
            collect(vecs[i].sel, 1'b0);
            exp_q.delete();
            for (int k = 0; k < vecs[i].len; k++)
                exp_q.push_back(vecs[i].exp[2*(vecs[i].len-1-k) +: 2]);
            compare($sformatf("vec%0d", i));
        end

        // Backpressure after the third digit, with an in_valid pulse that must be ignored.
        wait_idle();
        offer(0, 8'hA1, 1'b0, 1'b0);
        pre.delete();
        for (int k = 0; k < 3; k++) begin
            pre.push_back(out_digit0);
            step();
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = (k == 1);
            step();
            check("bp_valid", {31'd0, out_valid0}, 32'd1);
            check("bp_digit", {30'd0, out_digit0}, 32'd0);
            check("bp_last", {31'd0, out_last0}, 32'd0);
            check("bp_in_ready", {31'd0, in_ready0}, 32'd0);
        end
        in_valid = 1'b0;
        collect(0, 1'b0);
        for (int k = 2; k >= 0; k--) begin
            got_q.push_front(pre[k]);
            last_q.push_front(1'b0);
        end
        build_exp(0, 8'hA1, 1'b0, 1'b0);
        compare("backpressure");

        // Flush at the fourth digit, competing with digit advance and in_valid.
        wait_idle();
        offer(0, 8'hA1, 1'b0, 1'b0);
        step(); step(); step();
        flush = 1'b1; in_valid = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", {31'd0, out_valid0}, 32'd0);
        check("flush_out_last", {31'd0, out_last0}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready0}, 32'd1);
        check("flush_pad_busy", {31'd0, busy1}, 32'd0);
        offer(0, 8'h01, 1'b0, 1'b0);
        collect(0, 1'b0);
        build_exp(0, 8'h01, 1'b0, 1'b0);
        compare("after_flush");

        // Flush while idle outranks in_valid and leaves the block idle.
        wait_idle();
        flush = 1'b1; in_valid = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("idle_flush_busy", {31'd0, busy0}, 32'd0);
        check("idle_flush_valid", {31'd0, out_valid0}, 32'd0);

        // Asynchronous reset mid-stream.
        offer(0, 8'hA1, 1'b1, 1'b0);
        step(); step(); step();
        #2 rst = 1'b1;
        #1;
        check("rst_mid_out_valid", {31'd0, out_valid0}, 32'd0);
        check("rst_mid_in_ready", {31'd0, in_ready0}, 32'd1);
        check("rst_mid_busy", {31'd0, busy0}, 32'd0);
        check("rst_mid_digit", {30'd0, out_digit0}, 32'd0);
        check("rst_mid_last", {31'd0, out_last0}, 32'd0);
        step();
        rst = 1'b0;
        step();
        offer(0, 8'h01, 1'b0, 1'b0);
        collect(0, 1'b0);
        build_exp(0, 8'h01, 1'b0, 1'b0);
        compare("after_rst");

        // Random operands, random backpressure, both pad settings.
        for (int it = 0; it < 24; it++) begin
            sel = int'($urandom_range(0, 1));
            d   = W'($urandom);
            s   = 1'($urandom);
            m   = 1'($urandom);
            wait_idle();
            build_exp(sel == 0 ? 0 : 2, d, s, m);
            offer(sel, d, s, m);
            collect(sel, 1'b1);
            compare($sformatf("rnd%0d", it));
            check_value(d, s, m);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
